// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU core program-flow logic:
// opcode nibbles, instruction-cycle phases and the sequencer state type.
package cpu_pkg;

    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_FIN_JIN = 4'h3;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;
    localparam logic [3:0] OPR_BBL     = 4'hC;

    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X3 = 3'd7;

    typedef enum logic {
        FETCH1 = 1'b0,
        FETCH2 = 1'b1
    } seqState_t;

    // FIM and SRC share OPR 0x2; only FIM (OPA[0]=0) carries an operand word.
    function automatic logic isTwoWord(input logic [3:0] opr, input logic [3:0] opa);
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: isTwoWord = 1'b1;
            OPR_FIM_SRC:                        isTwoWord = ~opa[0];
            default:                            isTwoWord = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jcn_cond_eval.sv
// Conditional-jump evaluation. OPA[3] inverts the OR of the selected tests:
// OPA[2] accumulator zero, OPA[1] carry set, OPA[0] test pin low.
module jcn_cond_eval (
    input  logic [3:0] opa,
    input  logic       accZero,
    input  logic       carryFlag,
    input  logic       testIn,
    output logic       jumpTaken
);

    // Purely combinational condition reduction.
    always_comb begin
        jumpTaken = opa[3] ^ ((opa[2] & accZero) | (opa[1] & carryFlag) | (opa[0] & ~testIn));
    end

endmodule

// File: rtl/branch_sequencer.sv
// Program-flow controller: tracks one/two-word instructions across the
// 8-phase instruction cycle and decides every PC redirect and stack strobe.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH1 | first (or only) word; latches OPR/OPA, runs JIN and BBL
//   FETCH2 | operand word; latches A2/A1, runs JUN/JMS/JCN/ISZ/FIM
//
// Strobes are decoded from registered state and latched nibbles, gated to
// phase 7, so they fire exactly once at the edge ending the instruction.
module branch_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cycle,
    input  logic [3:0]  romData,
    input  logic [11:0] pcAddr,
    input  logic        accZero,
    input  logic        carryFlag,
    input  logic        testIn,
    input  logic        iszZero,
    input  logic [7:0]  pairData,
    input  logic [11:0] stackTop,
    output logic        pcLoad,
    output logic [11:0] pcNew,
    output logic        push,
    output logic        pop,
    output logic [11:0] retAddr,
    output logic        secondWord
);

    seqState_t   state;
    seqState_t   stateNext;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [3:0]  a2;
    logic [3:0]  a1;
    logic [11:0] nextAddr;
    logic        jcnTaken;
    logic        lastPhase;

    assign nextAddr   = pcAddr + 12'd1;
    assign lastPhase  = (cycle == CYC_X3);
    assign secondWord = (state == FETCH2);

    jcn_cond_eval uJcnCond (
        .opa       (opa),
        .accZero   (accZero),
        .carryFlag (carryFlag),
        .testIn    (testIn),
        .jumpTaken (jcnTaken)
    );

    // State register and nibble latches; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH1;
            opr   <= 4'h0;
            opa   <= 4'h0;
            a2    <= 4'h0;
            a1    <= 4'h0;
        end else begin
            state <= stateNext;
            if (state == FETCH1) begin
                if (cycle == CYC_M1) opr <= romData;
                if (cycle == CYC_M2) opa <= romData;
            end else begin
                if (cycle == CYC_M1) a2 <= romData;
                if (cycle == CYC_M2) a1 <= romData;
            end
        end
    end

    // Next-state: word boundary is the phase-7 edge.
    always_comb begin
        stateNext = state;
        if (lastPhase) begin
            if (state == FETCH1) begin
                stateNext = isTwoWord(opr, opa) ? FETCH2 : FETCH1;
            end else begin
                stateNext = FETCH1;
            end
        end
    end

    // Redirect and stack strobe decode for the instruction ending this cycle.
    always_comb begin
        pcLoad  = 1'b0;
        pcNew   = 12'h000;
        push    = 1'b0;
        pop     = 1'b0;
        retAddr = 12'h000;
        if (lastPhase) begin
            if (state == FETCH1) begin
                if (opr == OPR_FIN_JIN && opa[0]) begin
                    pcLoad = 1'b1;
                    pcNew  = {nextAddr[11:8], pairData};
                end else if (opr == OPR_BBL) begin
                    pcLoad = 1'b1;
                    pop    = 1'b1;
                    pcNew  = stackTop;
                end
            end else begin
                case (opr)
                    OPR_JUN: begin
                        pcLoad = 1'b1;
                        pcNew  = {opa, a2, a1};
                    end
                    OPR_JMS: begin
                        pcLoad  = 1'b1;
                        pcNew   = {opa, a2, a1};
                        push    = 1'b1;
                        retAddr = nextAddr;
                    end
                    OPR_JCN: begin
                        if (jcnTaken) begin
                            pcLoad = 1'b1;
                            pcNew  = {nextAddr[11:8], a2, a1};
                        end
                    end
                    OPR_ISZ: begin
                        if (!iszZero) begin
                            pcLoad = 1'b1;
                            pcNew  = {nextAddr[11:8], a2, a1};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: each word is stepped through phases
// 0..7 with hand-computed expectations checked just before the phase-7 edge.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cycle;
    logic [3:0]  romData;
    logic [11:0] pcAddr;
    logic        accZero;
    logic        carryFlag;
    logic        testIn;
    logic        iszZero;
    logic [7:0]  pairData;
    logic [11:0] stackTop;
    logic        pcLoad;
    logic [11:0] pcNew;
    logic        push;
    logic        pop;
    logic [11:0] retAddr;
    logic        secondWord;

    int passCount = 0;
    int totalCount = 0;

    branch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cycle      (cycle),
        .romData    (romData),
        .pcAddr     (pcAddr),
        .accZero    (accZero),
        .carryFlag  (carryFlag),
        .testIn     (testIn),
        .iszZero    (iszZero),
        .pairData   (pairData),
        .stackTop   (stackTop),
        .pcLoad     (pcLoad),
        .pcNew      (pcNew),
        .push       (push),
        .pop        (pop),
        .retAddr    (retAddr),
        .secondWord (secondWord)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One full word: nibble n3 at phase 3, n4 at phase 4.
    task automatic runWord(input string tag, input logic [11:0] addr,
                           input logic [3:0] n3, input logic [3:0] n4,
                           input logic expSecond, input logic expLoad,
                           input logic [11:0] expNew, input logic expPush,
                           input logic expPop, input logic [11:0] expRet);
        pcAddr = addr;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cycle   = 3'(c);
            romData = (c == 3) ? n3 : ((c == 4) ? n4 : 4'h0);
            #1;
            if (c == 6) begin
                check({tag, ".earlyStrobe"}, {9'd0, pcLoad, push, pop}, 12'h000);
            end
            if (c == 7) begin
                check({tag, ".secondWord"}, {11'd0, secondWord}, {11'd0, expSecond});
                check({tag, ".pcLoad"}, {11'd0, pcLoad}, {11'd0, expLoad});
                check({tag, ".push"}, {11'd0, push}, {11'd0, expPush});
                check({tag, ".pop"}, {11'd0, pop}, {11'd0, expPop});
                if (expLoad) check({tag, ".pcNew"}, pcNew, expNew);
                if (expPush) check({tag, ".retAddr"}, retAddr, expRet);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cycle = 3'd0; romData = 4'h0; pcAddr = 12'h000;
        accZero = 1'b0; carryFlag = 1'b0; testIn = 1'b1; iszZero = 1'b0;
        pairData = 8'h00; stackTop = 12'h000;
        repeat (3) @(negedge clk);
        cycle = 3'd7;
        #1;
        check("reset.pcLoad", {11'd0, pcLoad}, 12'h000);
        check("reset.pcNew", pcNew, 12'h000);
        check("reset.strobes", {10'd0, push, pop}, 12'h000);
        check("reset.retAddr", retAddr, 12'h000);
        check("reset.secondWord", {11'd0, secondWord}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        cycle = 3'd0;

        // JUN 0x35A
        runWord("jun1", 12'h010, 4'h4, 4'h3, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jun2", 12'h011, 4'h5, 4'hA, 1, 1, 12'h35A, 0, 0, 12'h000);

        // JMS 0x102 from 0x0F0, then NOP, then BBL
        runWord("jms1", 12'h0F0, 4'h5, 4'h1, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jms2", 12'h0F1, 4'h0, 4'h2, 1, 1, 12'h102, 1, 0, 12'h0F2);
        runWord("nop", 12'h102, 4'h0, 4'h0, 0, 0, 12'h000, 0, 0, 12'h000);
        stackTop = 12'h0F2;
        runWord("bbl", 12'h103, 4'hC, 4'h0, 0, 1, 12'h0F2, 0, 1, 12'h000);

        // JCN across page boundary
        accZero = 1'b1;
        runWord("jcnA1", 12'h2FE, 4'h1, 4'h4, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jcnA2", 12'h2FF, 4'h1, 4'h0, 1, 1, 12'h310, 0, 0, 12'h000);
        accZero = 1'b0;
        runWord("jcnB1", 12'h2FE, 4'h1, 4'h4, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jcnB2", 12'h2FF, 4'h1, 4'h0, 1, 0, 12'h000, 0, 0, 12'h000);
        runWord("jcnC1", 12'h2FE, 4'h1, 4'hC, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jcnC2", 12'h2FF, 4'h1, 4'h0, 1, 1, 12'h310, 0, 0, 12'h000);
        accZero = 1'b1;
        runWord("jcnD1", 12'h2FE, 4'h1, 4'hC, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jcnD2", 12'h2FF, 4'h1, 4'h0, 1, 0, 12'h000, 0, 0, 12'h000);
        // carry test, same page
        accZero = 1'b0; carryFlag = 1'b1;
        runWord("jcnE1", 12'h120, 4'h1, 4'h2, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jcnE2", 12'h121, 4'h6, 4'h9, 1, 1, 12'h169, 0, 0, 12'h000);
        carryFlag = 1'b0;

        // ISZ
        iszZero = 1'b0;
        runWord("iszA1", 12'h500, 4'h7, 4'h3, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("iszA2", 12'h501, 4'h2, 4'h4, 1, 1, 12'h524, 0, 0, 12'h000);
        iszZero = 1'b1;
        runWord("iszB1", 12'h500, 4'h7, 4'h3, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("iszB2", 12'h501, 4'h2, 4'h4, 1, 0, 12'h000, 0, 0, 12'h000);

        // FIM two words; FIN one word
        runWord("fim1", 12'h600, 4'h2, 4'h0, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("fim2", 12'h601, 4'h1, 4'h2, 1, 0, 12'h000, 0, 0, 12'h000);
        runWord("fin", 12'h602, 4'h3, 4'h0, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("afterFin", 12'h603, 4'h0, 4'h0, 0, 0, 12'h000, 0, 0, 12'h000);

        // JIN, including 4 KiB wrap
        pairData = 8'h37;
        runWord("jin", 12'h4FF, 4'h3, 4'h1, 0, 1, 12'h537, 0, 0, 12'h000);
        runWord("jinWrap", 12'hFFF, 4'h3, 4'h1, 0, 1, 12'h037, 0, 0, 12'h000);

        // Reset at phase 5 of a JMS operand word aborts it
        runWord("jmsR1", 12'h0F0, 4'h5, 4'h1, 0, 0, 12'h000, 0, 0, 12'h000);
        pcAddr = 12'h0F1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cycle   = 3'(c);
            romData = (c == 3) ? 4'h0 : ((c == 4) ? 4'h2 : 4'h0);
            rst     = (c == 5);
            #1;
            if (c == 4) check("jmsR2.secondWordBefore", {11'd0, secondWord}, 12'h001);
            if (c == 7) begin
                check("jmsR2.pcLoad", {11'd0, pcLoad}, 12'h000);
                check("jmsR2.push", {11'd0, push}, 12'h000);
                check("jmsR2.secondWord", {11'd0, secondWord}, 12'h000);
            end
        end
        rst = 1'b0;
        runWord("postReset", 12'h0F2, 4'h0, 4'h2, 0, 0, 12'h000, 0, 0, 12'h000);
        // Normal operation resumes afterwards
        runWord("jun3", 12'h0F3, 4'h4, 4'h7, 0, 0, 12'h000, 0, 0, 12'h000);
        runWord("jun4", 12'h0F4, 4'h1, 4'hE, 1, 1, 12'h71E, 0, 0, 12'h000);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
